cog_ctrx: RTL and testbench

//  Per-cog counter, next generation: parametrised accumulator width and pin count.

---
 rtl/cog_ctrx.sv | 157 +++++++++++++++
 tb/tb_cog_ctrx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cog_ctrx.sv
// Per-cog counter: NCO/duty/edge/logic modes, programmable period with wrap pulse.
// Define COG_CTRX_CAPTURE_EN to add the edge-capture register (cap tied to 0 otherwise).
module cog_ctrx #(
  parameter int W    = 32,
  parameter int NPIN = 32,
  parameter int PS   = 5
) (
  input  logic            clk_cog,
  input  logic            nres,
  input  logic            ena,
  input  logic            setctr,
  input  logic            setfrq,
  input  logic            setphs,
  input  logic            setprd,
  input  logic [31:0]     data,
  input  logic [NPIN-1:0] pin_in,
  output logic [W:0]      phs,
  output logic [NPIN-1:0] pin_out,
  output logic            wrap,
  output logic [W-1:0]    cap
);

  logic [31:0]  ctr_q, ctr_d;
  logic [W-1:0] frq_q, frq_d;
  logic [W-1:0] prd_q, prd_d;
  logic [W:0]   phs_q, phs_d;
  logic [1:0]   dly_q, dly_d;
  logic         wrap_q, wrap_d;

  logic [4:0]   mode;
  logic [3:0]   lut;
  logic [31:0]  a_idx, b_idx;
  logic         pin_a, pin_b;
  logic         trig, outa, outb;
  logic         edge_mode;
  logic [W:0]   sum, diff;
  logic         unused_ctr;

  assign mode      = ctr_q[30:26];
  assign lut       = ctr_q[29:26];
  assign a_idx     = 32'(ctr_q[PS-1:0]);
  assign b_idx     = 32'(ctr_q[9+PS-1:9]);
  assign edge_mode = (mode[4:3] == 2'b01) && mode[1];
  assign unused_ctr = ^{ctr_q[31], ctr_q[25:9+PS], ctr_q[8:PS]};

  // Pins beyond NPIN read as 0 rather than wrapping onto a real pin.
  assign pin_a = (a_idx < 32'(NPIN)) ? pin_in[ctr_q[PS-1:0]]   : 1'b0;
  assign pin_b = (b_idx < 32'(NPIN)) ? pin_in[ctr_q[9+PS-1:9]] : 1'b0;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    trig = 1'b0;
    outa = 1'b0;
    outb = 1'b0;
    casez (mode)
      5'b0010?: begin
        trig = 1'b1;
        outa = phs_q[W-1];
        outb = mode[0] & ~phs_q[W-1];
      end
      5'b0011?: begin
        trig = 1'b1;
        outa = phs_q[W];
        outb = mode[0] & ~phs_q[W];
      end
      5'b0100?: trig = dly_q[0];
      5'b0101?: trig = (dly_q == 2'b01);
      5'b0110?: trig = ~dly_q[0];
      5'b0111?: trig = (dly_q == 2'b10);
      5'b1????: trig = lut[dly_q];
      default:  trig = 1'b0;
    endcase
    if ((mode[4:3] == 2'b01) && mode[0]) outb = ~dly_q[0];
  end

  always_comb begin
    pin_out = '0;
    for (int i = 0; i < NPIN; i++) begin
      pin_out[i] = (outa && (a_idx == 32'(i))) || (outb && (b_idx == 32'(i)));
    end
  end

  assign sum  = {1'b0, phs_q[W-1:0]} + {1'b0, frq_q};
  assign diff = sum - {1'b0, prd_q};

  always_comb begin
    ctr_d  = ctr_q;
    frq_d  = setfrq ? data[W-1:0] : frq_q;
    prd_d  = setprd ? data[W-1:0] : prd_q;
    phs_d  = phs_q;
    wrap_d = 1'b0;
    dly_d  = dly_q;

    if (!ena)        ctr_d = '0;
    else if (setctr) ctr_d = data;

    // Logic modes sample both pins; edge/level modes keep a two-deep history of A.
    if (ctr_q[30])        dly_d = {pin_b, pin_a};
    else if (ctr_q[29])   dly_d = {dly_q[0], pin_a};

    // A single subtraction only: with frq >= prd the result may stay >= prd.
    if (setphs) begin
      phs_d = {1'b0, data[W-1:0]};
    end else if (trig) begin
      if (prd_q == '0) begin
        phs_d  = sum;
        wrap_d = sum[W];
      end else if (sum >= {1'b0, prd_q}) begin
        phs_d  = {1'b1, diff[W-1:0]};
        wrap_d = 1'b1;
      end else begin
        phs_d  = sum;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      ctr_q  <= '0;
      frq_q  <= '0;
      prd_q  <= '0;
      phs_q  <= '0;
      dly_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      ctr_q  <= ctr_d;
      frq_q  <= frq_d;
      prd_q  <= prd_d;
      phs_q  <= phs_d;
      dly_q  <= dly_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef COG_CTRX_CAPTURE_EN
  logic [W-1:0] cap_q, cap_d;

  // Captures the pre-update phs, even when setphs overrides the accumulate.
  assign cap_d = (trig && edge_mode) ? phs_q[W-1:0] : cap_q;

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) cap_q <= '0;
    else       cap_q <= cap_d;
  end

  assign cap = cap_q;
`else
  logic unused_edge;
  assign unused_edge = edge_mode;
  assign cap = '0;
`endif

  assign phs  = phs_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_cog_ctrx.sv
// Self-checking bench for cog_ctrx: directed spot checks plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_cog_ctrx;
  localparam int W    = 32;
  localparam int NPIN = 24;
  localparam int PS   = 5;
  localparam longint MOD  = longint'(1) << W;
  localparam longint MASK = MOD - 1;

  typedef enum int {WR_CTR, WR_FRQ, WR_PHS, WR_PRD} wr_e;

  logic            clk = 1'b0;
  logic            nres = 1'b0;
  logic            ena = 1'b0;
  logic            setctr = 1'b0, setfrq = 1'b0, setphs = 1'b0, setprd = 1'b0;
  logic [31:0]     data = '0;
  logic [NPIN-1:0] pin_in = '0;
  logic [W:0]      phs;
  logic [NPIN-1:0] pin_out;
  logic            wrap;
  logic [W-1:0]    cap;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  cog_ctrx #(.W(W), .NPIN(NPIN), .PS(PS)) dut (
    .clk_cog(clk), .nres(nres), .ena(ena),
    .setctr(setctr), .setfrq(setfrq), .setphs(setphs), .setprd(setprd),
    .data(data), .pin_in(pin_in),
    .phs(phs), .pin_out(pin_out), .wrap(wrap), .cap(cap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counter state as plain integers, rules applied arithmetically.
  logic [31:0] m_ctr = '0;
  longint      m_phs = 0, m_frq = 0, m_prd = 0, m_cap = 0;
  int          m_dly = 0;
  bit          m_wrap = 1'b0;
  bit          m_trig;
  longint      m_sum;
  int          m_mode;

  function automatic int mode_of();
    return int'(m_ctr[30:26]);
  endfunction

  function automatic bit pin_at(input int idx);
    return (idx < NPIN) ? pin_in[idx] : 1'b0;
  endfunction

  function automatic bit model_trig();
    int md = mode_of();
    if (md >= 16) return m_ctr[26 + m_dly];
    if (md >= 4 && md <= 7) return 1'b1;
    if (md >= 8) begin
      case ((md - 8) / 2)
        0:       return (m_dly & 1) == 1;
        1:       return m_dly == 1;
        2:       return (m_dly & 1) == 0;
        default: return m_dly == 2;
      endcase
    end
    return 1'b0;
  endfunction

  function automatic logic [NPIN-1:0] model_pins();
    int md = mode_of();
    int a  = int'(m_ctr[4:0]);
    int b  = int'(m_ctr[13:9]);
    bit oa = 1'b0, ob = 1'b0, v;
    logic [NPIN-1:0] r = '0;
    if (md >= 4 && md <= 7) begin
      v  = (md >= 6) ? (((m_phs >> W) & 1) != 0) : (((m_phs >> (W - 1)) & 1) != 0);
      oa = v;
      ob = (md % 2 == 1) && !v;
    end else if (md >= 8 && md <= 15 && md % 2 == 1) begin
      ob = (m_dly & 1) == 0;
    end
    if (oa && a < NPIN) r[a] = 1'b1;
    if (ob && b < NPIN) r[b] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge nres) begin
    if (!nres) begin
      m_ctr = '0; m_phs = 0; m_frq = 0; m_prd = 0; m_cap = 0; m_dly = 0; m_wrap = 1'b0;
    end else begin
      m_mode = mode_of();
      m_trig = model_trig();
      m_sum  = (m_phs % MOD) + m_frq;
      m_wrap = 1'b0;
`ifdef COG_CTRX_CAPTURE_EN
      if (m_trig && (m_mode == 10 || m_mode == 11 || m_mode == 14 || m_mode == 15))
        m_cap = m_phs % MOD;
`endif
      if (setphs) m_phs = longint'(data) & MASK;
      else if (m_trig) begin
        if (m_prd == 0) begin
          m_phs  = m_sum;
          m_wrap = m_sum >= MOD;
        end else if (m_sum >= m_prd) begin
          m_phs  = MOD + ((m_sum - m_prd) % MOD);
          m_wrap = 1'b1;
        end else begin
          m_phs = m_sum;
        end
      end
      if (m_mode >= 16)
        m_dly = 2 * int'(pin_at(int'(m_ctr[13:9]))) + int'(pin_at(int'(m_ctr[4:0])));
      else if (m_mode >= 8)
        m_dly = ((m_dly & 1) << 1) | int'(pin_at(int'(m_ctr[4:0])));
      if (setfrq) m_frq = longint'(data) & MASK;
      if (setprd) m_prd = longint'(data) & MASK;
      if (!ena)        m_ctr = '0;
      else if (setctr) m_ctr = data;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("phs", 64'(phs), m_phs);
      check("wrap", 64'(wrap), 64'(m_wrap));
      check("pin_out", 64'(pin_out), 64'(model_pins()));
`ifdef COG_CTRX_CAPTURE_EN
      check("cap", 64'(cap), m_cap);
`else
      check("cap", 64'(cap), 64'd0);
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input wr_e which, input logic [31:0] d);
    data = d;
    case (which)
      WR_CTR:  setctr = 1'b1;
      WR_FRQ:  setfrq = 1'b1;
      WR_PHS:  setphs = 1'b1;
      default: setprd = 1'b1;
    endcase
    tick();
    setctr = 1'b0; setfrq = 1'b0; setphs = 1'b0; setprd = 1'b0;
  endtask

  function automatic logic [31:0] rand_ctr();
    logic [31:0] d;
    d = ($urandom & 32'h83FF_C1E0);
    d[30:26] = 5'($urandom_range(0, 31));
    d[13:9]  = 5'($urandom_range(0, 31));
    d[4:0]   = 5'($urandom_range(0, 31));
    return d;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 20));
      1:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  longint exp_p[7] = '{3, 6, 9, 64'h1_0000_0002, 5, 8, 64'h1_0000_0001};
  bit     exp_w[7] = '{0, 0, 0, 1, 0, 0, 1};
  int     hi_cnt;
  int     r;

  initial begin
    ena = 1'b1;
    tick();
    chk_en = 1'b1;
    check("rst_phs", 64'(phs), 64'd0);
    check("rst_pin_out", 64'(pin_out), 64'd0);
    check("rst_wrap", 64'(wrap), 64'd0);
    check("rst_cap", 64'(cap), 64'd0);
    nres = 1'b1;
    tick();

    // NCO, A=3, quarter-turn steps
    wr(WR_FRQ, 32'h4000_0000);
    wr(WR_PHS, 32'd0);
    wr(WR_CTR, (32'd4 << 26) | 32'd3);
    hi_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("nco_phs_top", 64'(phs[31:30]), 64'(k % 4));
      hi_cnt += int'(pin_out[3]);
    end
    check("nco_duty", 64'(hi_cnt), 64'd4);

    // period 10, step 3
    wr(WR_CTR, 32'd0);
    wr(WR_FRQ, 32'd3);
    wr(WR_PRD, 32'd10);
    wr(WR_PHS, 32'd0);
    wr(WR_CTR, (32'd4 << 26) | 32'd3);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("prd_phs", 64'(phs), exp_p[k]);
      check("prd_wrap", 64'(wrap), 64'(exp_w[k]));
    end

    // setphs overrides a running accumulate
    wr(WR_PHS, 32'd7);
    check("setphs_phs", 64'(phs), 64'd7);
    check("setphs_wrap", 64'(wrap), 64'd0);
    tick();
    check("resume_phs", 64'(phs), 64'h1_0000_0000);
    check("resume_wrap", 64'(wrap), 64'd1);

    // positive-edge counting on pin 5
    wr(WR_CTR, 32'd0);
    wr(WR_FRQ, 32'd1);
    wr(WR_PRD, 32'd0);
    wr(WR_PHS, 32'd0);
    pin_in = '0;
    wr(WR_CTR, (32'h0A << 26) | 32'd5);
    tick();
    for (int p = 0; p < 3; p++) begin
      pin_in[5] = 1'b1;
      tick();
      tick();
      if (p == 2) check("edge_count", 64'(phs), 64'd3);
      pin_in[5] = 1'b0;
      tick();
      tick();
    end

    // A out of range (28 >= NPIN), B=2, differential NCO
    wr(WR_CTR, 32'd0);
    wr(WR_CTR, (32'd5 << 26) | (32'd2 << 9) | 32'd28);
    wr(WR_PHS, 32'h8000_0000);
    check("oor_a_suppressed", 64'(pin_out), 64'd0);
    wr(WR_PHS, 32'd0);
    check("oor_b_driven", 64'(pin_out), 64'h4);
    tick();
    check("pre_rst_phs", 64'(phs), 64'd1);
    nres = 1'b0;
    #1;
    check("async_rst_phs", 64'(phs), 64'd0);
    check("async_rst_pin_out", 64'(pin_out), 64'd0);
    check("async_rst_wrap", 64'(wrap), 64'd0);
    #1;
    nres = 1'b1;
    tick();

    // negative-edge capture on pin 5
    wr(WR_FRQ, 32'd1);
    pin_in = '0;
    pin_in[5] = 1'b1;
    wr(WR_CTR, (32'h0E << 26) | 32'd5);
    tick();
    tick();
    wr(WR_PHS, 32'd4);
    pin_in[5] = 1'b0;
    tick();
    tick();
    check("cap_phs", 64'(phs), 64'd5);
`ifdef COG_CTRX_CAPTURE_EN
    check("cap_value", 64'(cap), 64'd4);
`else
    check("cap_value", 64'(cap), 64'd0);
`endif

    // randomized traffic, checked each cycle by the compare process
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        nres = 1'b0;
        #1;
        nres = 1'b1;
      end
      ena    = ($urandom_range(0, 19) != 0);
      pin_in = NPIN'($urandom);
      r = $urandom_range(0, 11);
      case (r)
        0, 1: begin data = rand_ctr(); setctr = 1'b1; end
        2:    begin data = rand_val(); setfrq = 1'b1; end
        3:    begin data = rand_val(); setphs = 1'b1; end
        4:    begin data = rand_val(); setprd = 1'b1; end
        5:    begin data = rand_val(); setfrq = 1'b1; setprd = 1'b1; setphs = 1'b1; end
        default: data = $urandom;
      endcase
      tick();
      setctr = 1'b0; setfrq = 1'b0; setphs = 1'b0; setprd = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
